// File: rtl/inst_loader_pkg.sv
// Shared types and helpers for the boot-time instruction loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE, LD_LEN, LD_DATA, LD_FIN, LD_CHK, LD_DONE, LD_ERR
  } ld_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Word index to byte address; wraps modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs accepted bytes MSB first into 32-bit words; word_vld_o fires with the 4th byte.
module inst_loader_byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_vld_o
);

  logic [1:0]  cnt_q;
  logic [23:0] sh_q;

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (take_i) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {sh_q[15:0], byte_i};
    end
  end

  // The 4th byte completes the word combinationally so the write lands one cycle later.
  assign word_o     = {sh_q, byte_i};
  assign word_vld_o = take_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed big-endian word image into instruction RAM, holding the CPU until done.
// Optional trailing XOR checksum byte: define INST_LOADER_CKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 131071
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  ld_state_e   state_q;
  logic [31:0] len_q, idx_q, mem_addr_q, mem_data_q;
  logic        in_ready_q, mem_we_q, busy_q, done_q, err_q, cpu_hold_q;
`ifdef INST_LOADER_CKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic        start_ok, take, pk_vld;
  logic [31:0] pk_word;

  // start is only honoured when no load is in flight.
  assign start_ok = start && (state_q == LD_IDLE || state_q == LD_DONE || state_q == LD_ERR);
  assign take     = in_valid && in_ready_q && (state_q == LD_LEN || state_q == LD_DATA);

  inst_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_ok),
    .take_i    (take),
    .byte_i    (in_data),
    .word_o    (pk_word),
    .word_vld_o(pk_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LD_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef INST_LOADER_CKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (start_ok) begin
        state_q    <= LD_LEN;
        len_q      <= '0;
        idx_q      <= '0;
        in_ready_q <= 1'b1;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        cpu_hold_q <= 1'b1;
`ifdef INST_LOADER_CKSUM_EN
        xor_q      <= '0;
`endif
      end else begin
        case (state_q)
          LD_LEN: if (pk_vld) begin
            len_q <= pk_word;
            if (pk_word == 32'd0) begin
              state_q    <= LD_FIN;
              in_ready_q <= 1'b0;
            end else if (pk_word > MAX_WORDS) begin
              state_q    <= LD_ERR;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= LD_DATA;
            end
          end
          LD_DATA: begin
`ifdef INST_LOADER_CKSUM_EN
            if (take) xor_q <= xor_q ^ in_data;
`endif
            if (pk_vld) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= word_addr(BASE_ADDR, idx_q);
              mem_data_q <= pk_word;
              idx_q      <= idx_q + 32'd1;
              if (idx_q + 32'd1 == len_q) begin
                state_q    <= LD_FIN;
                in_ready_q <= 1'b0;
              end
            end
          end
`ifdef INST_LOADER_CKSUM_EN
          LD_FIN: begin
            state_q    <= LD_CHK;
            in_ready_q <= 1'b1;
          end
          LD_CHK: if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (in_data == xor_q) begin
              state_q    <= LD_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= LD_ERR;
              err_q   <= 1'b1;
            end
          end
`else
          LD_FIN: begin
            state_q    <= LD_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed streams, a vector table of loads, random stalls.
module tb_inst_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 131071;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, busy, done, err, cpu_hold;
  logic [31:0] mem_addr, mem_data;

  inst_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Write monitor: logs every mem_we cycle and counts back-to-back pulses.
  logic [31:0] wr_a[$], wr_d[$];
  int          b2b = 0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_data);
      if (prev_we) b2b++;
    end
    prev_we = mem_we;
  end

  logic [31:0] words[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts and ends at a negedge; stall probability pct percent before offering the byte.
  task automatic send_byte(input logic [7:0] b, input int pct);
    int guard;
    while ($urandom_range(99, 0) < pct) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int pct);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], pct);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Full load: length, nsend words from `words`, optional trailer, then wait for completion.
  task automatic run_load(input logic [31:0] len, input int nsend, input int pct, input bit bad_sum);
    logic [7:0] x;
    int g;
    x = 8'h00;
    pulse_start();
    send_word(len, pct);
    for (int w = 0; w < nsend; w++) begin
      send_word(words[w], pct);
      x = x ^ words[w][31:24] ^ words[w][23:16] ^ words[w][15:8] ^ words[w][7:0];
    end
`ifdef INST_LOADER_CKSUM_EN
    if (len <= MAXW) send_byte(x ^ {7'd0, bad_sum}, pct);
`else
    if (bad_sum) x = ~x;
`endif
    g = 0;
    while (!(done || err) && g < 40) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  // Reference: a legal length yields exactly len writes at consecutive word addresses.
  task automatic check_end(input string nm, input logic [31:0] len, input int wbase, input int b2b0,
                           input bit exp_done, input bit exp_err);
    int n;
    n = (len <= MAXW) ? int'(len) : 0;
    chk({nm, ".done"}, 32'(done), 32'(exp_done));
    chk({nm, ".err"}, 32'(err), 32'(exp_err));
    chk({nm, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    chk({nm, ".busy"}, 32'(busy), 32'd0);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, ".nwrites"}, 32'(wr_a.size() - wbase), 32'(n));
    chk({nm, ".b2b_we"}, 32'(b2b - b2b0), 32'd0);
    for (int i = 0; i < n && (wbase + i) < wr_a.size(); i++) begin
      chk($sformatf("%s.addr%0d", nm, i), wr_a[wbase + i], BASE + 32'(4 * i));
      chk($sformatf("%s.data%0d", nm, i), wr_d[wbase + i], words[i]);
    end
  endtask

  typedef struct {
    logic [31:0] len;
    int          nsend;
    int          pct;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int wb, bb;

    vecs[0] = '{32'd2,          2,  50, 1'b1, 1'b0};
    vecs[1] = '{32'h0002_0000,  0,  0,  1'b0, 1'b1};
    vecs[2] = '{32'd3,          3,  0,  1'b1, 1'b0};
    vecs[3] = '{32'd0,          0,  0,  1'b1, 1'b0};
    vecs[4] = '{32'd5,          5,  30, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF,  0,  20, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.mem_addr", mem_addr, BASE);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.in_ready", 32'(in_ready), 32'd0);

    // Reference stream from the boot image example.
    words = '{32'h3C01_1234, 32'h3421_5678};
    wb = wr_a.size(); bb = b2b;
    run_load(32'd2, 2, 0, 1'b0);
    check_end("basic", 32'd2, wb, bb, 1'b1, 1'b0);
    chk("basic.hold_addr", mem_addr, BASE + 32'd4);
    chk("basic.hold_data", mem_data, 32'h3421_5678);

    for (int v = 0; v < 6; v++) begin
      words.delete();
      for (int i = 0; i < vecs[v].nsend; i++) words.push_back($urandom);
      wb = wr_a.size(); bb = b2b;
      run_load(vecs[v].len, vecs[v].nsend, vecs[v].pct, 1'b0);
      check_end($sformatf("vec%0d", v), vecs[v].len, wb, bb, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Reset after 6 of 8 data bytes: second word never written, reset values restored.
    words = '{32'h3C01_1234, 32'h3421_5678};
    wb = wr_a.size();
    pulse_start();
    send_word(32'd2, 0);
    send_word(words[0], 0);
    send_byte(8'h34, 0);
    send_byte(8'h21, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.nwrites", 32'(wr_a.size() - wb), 32'd1);
    chk("midrst.mem_we", 32'(mem_we), 32'd0);
    chk("midrst.mem_data", mem_data, 32'd0);
    chk("midrst.mem_addr", mem_addr, BASE);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    chk("midrst.cpu_hold", 32'(cpu_hold), 32'd1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.no_late_we", 32'(wr_a.size() - wb), 32'd1);

`ifdef INST_LOADER_CKSUM_EN
    words = '{32'h1122_3344};
    wb = wr_a.size(); bb = b2b;
    run_load(32'd1, 1, 0, 1'b0);
    check_end("cksum_ok", 32'd1, wb, bb, 1'b1, 1'b0);
    wb = wr_a.size(); bb = b2b;
    run_load(32'd1, 1, 0, 1'b1);
    check_end("cksum_bad", 32'd1, wb, bb, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached=1 required=0");
    $fatal(1, "timeout");
  end

endmodule
